ysyx_idu_ifq: RTL and testbench
===============================

# ysyx_idu_ifq

Instruction fetch queue and issue sequencer between the IFU and the IDU. It decouples fetch bursts from decode back-pressure with a small circular buffer. It drops all in-flight entries on a pipeline flush. After a faulting fetch it stops accepting instructions, so nothing younger than a trapping instruction reaches decode. The IFU drives its slave side and the IDU pulls from its master side.

## Interface
- `DEPTH`, default 4: number of queue entries; power of two, at least 2.
- `XLEN`, default `` `YSYX_XLEN ``: width of pnpc and cause.
- `CW`, default `$clog2(DEPTH+1)`: width of the occupancy count.

Ports:
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `flush_pipe`  in  1  pipeline flush, from `cmu_bcast.flush_pipe`.
- `in_valid`  in  1  IFU entry valid.
- `in_ready`  out  1  queue can accept an entry.
- `in_inst`  in  32  raw instruction, possibly compressed.
- `in_pc`  in  32  pc of the instruction.
- `in_pnpc`  in  XLEN  predicted next pc.
- `in_trap`  in  1  fetch fault.
- `in_cause`  in  XLEN  fault cause.
- `out_valid`  out  1  head entry valid toward the IDU.
- `out_ready`  in  1  IDU accepts the head entry.
- `out_inst`, `out_pc`, `out_pnpc`, `out_trap`, `out_cause`  out  32/32/XLEN/1/XLEN  head entry fields.
- `count`  out  CW  current occupancy.
- `hold`  out  1  queue is in the HOLD state.

## Operation
- Storage: DEPTH entries, each {inst, pc, pnpc, trap, cause}.
  - Read pointer `rp` and write pointer `wp` are `$clog2(DEPTH)` bits and wrap naturally.
  - A separate `count` register distinguishes full from empty.
- Push occurs when `in_valid && in_ready && !flush_pipe`. Pop occurs when `out_valid && out_ready && !flush_pipe`.
- `in_ready` = `(state==RUN) && (count != DEPTH)`.
  - A full queue does not accept an entry in the same cycle as a pop; `in_ready` depends only on state and count.
- `out_valid` = `(count != 0) && !flush_pipe`. Output fields always present `mem[rp]`.
- Simultaneous push and pop: the entry is written at `wp`, `rp` advances, and `count` is unchanged.
- State machine, two states:
  - RUN: normal operation. A push with `in_trap=1` moves the queue to HOLD at the next edge, and that trapping entry is still stored.
  - HOLD: `in_ready`=0, while pops continue normally. The only exit is `flush_pipe`, which returns the queue to RUN. HOLD persists after the trap entry drains; the commit unit's flush is the only release.
- Flush (`flush_pipe`=1):
  - Next edge: `rp`=`wp`=0, `count`=0, state=RUN.
  - During the flush cycle no push or pop takes effect, and `out_valid` is forced to 0.
- `reset` has the same effect as flush, has priority over every other input, and applies mid-operation regardless of handshake state.

## Timing
- Reset values:
  - `in_ready`=1, `out_valid`=0, `count`=0, `hold`=0.
  - Data outputs are undefined (memory is not reset) and are don't-care while `out_valid`=0.
- Latency:
  - Without bypass, an entry pushed in cycle N is visible with `out_valid`=1 in cycle N+1.
  - With bypass, see Configuration.
- Throughput: one push and one pop per cycle sustained whenever 0 < count < DEPTH.
- `out_*` fields are stable while `out_valid && !out_ready`.
- `count` and `hold` are registered outputs. `in_ready` and `out_valid` are combinational from registered state and `flush_pipe` only, with no path from `in_valid` or `out_ready`.

## Configuration
- `YSYX_IFQ_BYPASS_EN` defined:
  - Condition: `count==0`, state RUN, `in_valid=1` and `flush_pipe=0`.
  - Then `out_valid`=1 and `out_*` mirror `in_*` in the same cycle.
  - If `out_ready`=1, the entry is consumed without being written, and `count` stays 0.
  - A bypassed entry with `in_trap=1` still moves the queue to HOLD.
  - This adds a combinational `in_valid`→`out_valid` path.
- Undefined: no combinational path from input to output; minimum latency is 1 cycle.

## Test plan
- **Fill and drain**, DEPTH=4, `out_ready`=0:
  - Push pc 0x1000, 0x1004, 0x1008, 0x100c. Then `count`=4, `in_ready`=0, and a fifth `in_valid` is not accepted.
  - Raise `out_ready`: pcs come out in order over 4 cycles, then `count`=0.
- **Wrap-around**: 10 back-to-back push/pop pairs with `out_ready`=1 and a 1-deep backlog.
  - Output pc sequence equals input sequence 0x2000…0x2024 with no loss or duplication.
  - `count` holds at 1.
- **Trap hold**: push 0x3000, then 0x3004 with `in_trap`=1 and `in_cause`=0xc.
  - Next cycle `hold`=1 and `in_ready`=0.
  - Both entries drain with `out_trap`=0 then 1 and `out_cause`=0xc.
  - `in_ready` stays 0 until `flush_pipe` is pulsed, after which `hold`=0 and `in_ready`=1.
- **Flush mid-stream**: with 3 entries queued, pulse `flush_pipe` while `in_valid`=1 and `out_ready`=1.
  - Same cycle `out_valid`=0; next cycle `count`=0.
  - The flush-cycle input is not stored.
- **Reset mid-operation**: with `count`=2 and HOLD, assert `reset` for 1 cycle.
  - Next cycle `count`=0, `hold`=0, `in_ready`=1, `out_valid`=0.
- **Bypass** (`YSYX_IFQ_BYPASS_EN`): empty queue, `in_valid`=1, pc 0x4000, `out_ready`=1.
  - Same cycle `out_valid`=1, `out_pc`=0x4000, and `count` remains 0.
  - Without the macro, `out_valid` rises one cycle later and `count` is 1 for one cycle.

Source files
------------

// File: rtl/ysyx_idu_ifq.sv
// ysyx_idu_ifq: instruction fetch queue between the IFU and the IDU.
// Circular buffer of DEPTH entries {inst, pc, pnpc, trap, cause}.
// Ports: clock, reset (sync, active-high), flush_pipe;
//   in_*  : IFU side (valid/ready, inst, pc, pnpc, trap, cause);
//   out_* : IDU side (valid/ready, head entry fields);
//   count : occupancy; hold : fetch stopped after a trap.
// Build option: define YSYX_IFQ_BYPASS_EN to pass an entry straight
//   through to the IDU in the same cycle while the queue is empty.
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif

module ysyx_idu_ifq #(
  parameter int DEPTH = 4,
  parameter int XLEN  = `YSYX_XLEN,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush_pipe,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [31:0]     in_pc,
  input  logic [XLEN-1:0] in_pnpc,
  input  logic            in_trap,
  input  logic [XLEN-1:0] in_cause,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [31:0]     out_pc,
  output logic [XLEN-1:0] out_pnpc,
  output logic            out_trap,
  output logic [XLEN-1:0] out_cause,
  output logic [CW-1:0]   count,
  output logic            hold
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0]     inst;
    logic [31:0]     pc;
    logic [XLEN-1:0] pnpc;
    logic            trap;
    logic [XLEN-1:0] cause;
  } ent_t;

  typedef enum logic {RUN, HOLD} state_t;

  state_t          state, state_n;
  ent_t            mem [DEPTH];
  ent_t            wr_e, head;
  logic [AW-1:0]   rp, wp;
  logic [CW-1:0]   cnt;
  logic            empty, full;
  logic            byp, accept, push, pop;

  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));

  assign wr_e.inst  = in_inst;
  assign wr_e.pc    = in_pc;
  assign wr_e.pnpc  = in_pnpc;
  assign wr_e.trap  = in_trap;
  assign wr_e.cause = in_cause;

`ifdef YSYX_IFQ_BYPASS_EN
  assign byp = empty && (state == RUN) && in_valid && !flush_pipe;
`else
  assign byp = 1'b0;
`endif

  assign in_ready  = (state == RUN) && !full;
  assign out_valid = (!empty && !flush_pipe) || byp;
  assign head      = byp ? wr_e : mem[rp];

  assign out_inst  = head.inst;
  assign out_pc    = head.pc;
  assign out_pnpc  = head.pnpc;
  assign out_trap  = head.trap;
  assign out_cause = head.cause;

  // accept covers a bypassed entry too, so a bypassed trap still holds
  assign accept = in_valid && in_ready && !flush_pipe;
  assign push   = accept && !(byp && out_ready);
  assign pop    = !empty && out_ready && !flush_pipe;

  assign count = cnt;
  assign hold  = (state == HOLD);

  always_ff @(posedge clock) begin
    if (push) mem[wp] <= wr_e;
  end

  always_ff @(posedge clock) begin
    if (reset || flush_pipe) begin
      rp  <= '0;
      wp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      if (push && !pop)      cnt <= cnt + CW'(1);
      else if (!push && pop) cnt <= cnt - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= RUN;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      RUN:  if (accept && in_trap) state_n = HOLD;
      HOLD: if (flush_pipe)        state_n = RUN;
      default: state_n = RUN;
    endcase
    if (flush_pipe) state_n = RUN;
  end

endmodule

// File: tb/tb_ysyx_idu_ifq.sv
// tb_ysyx_idu_ifq: directed plus random stimulus for ysyx_idu_ifq.
// Expected values come from a queue-based reference model.
module tb_ysyx_idu_ifq;

  logic        clock = 1'b0;
  logic        reset, flush_pipe;
  logic        in_valid, in_ready, in_trap;
  logic [31:0] in_inst, in_pc, in_pnpc, in_cause;
  logic        out_valid, out_ready, out_trap;
  logic [31:0] out_inst, out_pc, out_pnpc, out_cause;
  logic [2:0]  count;
  logic        hold;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] inst, pc, pnpc, cause;
    logic        trap;
  } ent_t;

  ent_t q[$];
  bit   mhold = 0;

  ysyx_idu_ifq #(.DEPTH(4), .XLEN(32)) dut (
    .clock(clock), .reset(reset), .flush_pipe(flush_pipe),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .in_pnpc(in_pnpc),
    .in_trap(in_trap), .in_cause(in_cause),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc), .out_pnpc(out_pnpc),
    .out_trap(out_trap), .out_cause(out_cause),
    .count(count), .hold(hold)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input bit v, input logic [31:0] pc,
                        input bit tr, input logic [31:0] cause);
    in_valid = v;
    in_pc    = pc;
    in_inst  = $urandom;
    in_pnpc  = $urandom;
    in_trap  = tr;
    in_cause = cause;
  endtask

  // One clock: check outputs against the model, take the edge,
  // then advance the model by the queue rules.
  task automatic cyc();
    bit   byp, e_rdy, e_ov;
    ent_t h, e;
    #1;
    e.inst = in_inst; e.pc = in_pc; e.pnpc = in_pnpc;
    e.trap = in_trap; e.cause = in_cause;
    e_rdy = !mhold && (q.size() < 4);
    byp = 0;
`ifdef YSYX_IFQ_BYPASS_EN
    byp = (q.size() == 0) && !mhold && in_valid && !flush_pipe;
`endif
    e_ov = !flush_pipe && (q.size() > 0 || byp);
    h = byp ? e : (q.size() > 0 ? q[0] : e);
    chk("count", count, q.size());
    chk("hold", hold, mhold);
    chk("in_ready", in_ready, e_rdy);
    chk("out_valid", out_valid, e_ov);
    if (e_ov) begin
      chk("out_pc", out_pc, h.pc);
      chk("out_inst", out_inst, h.inst);
      chk("out_pnpc", out_pnpc, h.pnpc);
      chk("out_trap", out_trap, h.trap);
      if (h.trap) chk("out_cause", out_cause, h.cause);
    end
    @(posedge clock);
    if (reset || flush_pipe) begin
      q.delete();
      mhold = 0;
    end else begin
      if (in_valid && e_rdy) begin
        q.push_back(e);
        if (in_trap) mhold = 1;
      end
      if (e_ov && out_ready) void'(q.pop_front());
    end
    #1;
  endtask

  initial begin
    reset = 1; flush_pipe = 0; out_ready = 0;
    set_in(0, 0, 0, 0);
    repeat (2) cyc();
    reset = 0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_hold", hold, 0);

    // fill and drain
    for (int i = 0; i < 4; i++) begin
      set_in(1, 32'h1000 + 4 * i, 0, 0);
      cyc();
    end
    chk("fill_count", count, 4);
    chk("fill_in_ready", in_ready, 0);
    set_in(1, 32'h1010, 0, 0);
    cyc();
    set_in(0, 0, 0, 0);
    out_ready = 1;
    repeat (4) cyc();
    chk("drain_count", count, 0);

    // wrap-around with a 1-deep backlog
    out_ready = 0;
    set_in(1, 32'h2000, 0, 0);
    cyc();
    out_ready = 1;
    for (int i = 1; i < 10; i++) begin
      set_in(1, 32'h2000 + 4 * i, 0, 0);
      cyc();
      chk("wrap_count", count, 1);
    end
    set_in(0, 0, 0, 0);
    cyc();

    // trap hold
    out_ready = 0;
    set_in(1, 32'h3000, 0, 0);
    cyc();
    set_in(1, 32'h3004, 1, 32'hc);
    cyc();
    chk("trap_hold", hold, 1);
    chk("trap_in_ready", in_ready, 0);
    set_in(1, 32'h3008, 0, 0);
    out_ready = 1;
    repeat (3) cyc();
    chk("trap_still_blocked", in_ready, 0);
    chk("trap_drained", count, 0);
    flush_pipe = 1;
    set_in(0, 0, 0, 0);
    cyc();
    flush_pipe = 0;
    chk("trap_release_hold", hold, 0);
    chk("trap_release_rdy", in_ready, 1);

    // flush mid-stream
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      set_in(1, 32'h5000 + 4 * i, 0, 0);
      cyc();
    end
    out_ready = 1;
    flush_pipe = 1;
    set_in(1, 32'h5100, 0, 0);
    #1 chk("flush_out_valid", out_valid, 0);
    cyc();
    flush_pipe = 0;
    set_in(0, 0, 0, 0);
    chk("flush_count", count, 0);
    cyc();

    // reset mid-operation in HOLD
    out_ready = 0;
    set_in(1, 32'h6000, 0, 0);
    cyc();
    set_in(1, 32'h6004, 1, 32'h2);
    cyc();
    chk("prerst_count", count, 2);
    chk("prerst_hold", hold, 1);
    set_in(0, 0, 0, 0);
    reset = 1;
    cyc();
    reset = 0;
    chk("midrst_count", count, 0);
    chk("midrst_hold", hold, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);

    // bypass / minimum latency
    out_ready = 1;
    set_in(1, 32'h4000, 0, 0);
`ifdef YSYX_IFQ_BYPASS_EN
    #1;
    chk("byp_out_valid", out_valid, 1);
    chk("byp_out_pc", out_pc, 32'h4000);
    cyc();
    chk("byp_count", count, 0);
`else
    #1 chk("lat_out_valid", out_valid, 0);
    cyc();
    chk("lat_count", count, 1);
    chk("lat_out_pc", out_pc, 32'h4000);
`endif
    set_in(0, 0, 0, 0);
    cyc();

    // randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      reset      = ($urandom % 100) == 0;
      flush_pipe = ($urandom % 20) == 0;
      out_ready  = ($urandom % 4) != 0;
      set_in(($urandom % 3) != 0, $urandom & 32'hffff_fffc,
             ($urandom % 16) == 0, $urandom);
      cyc();
    end
    reset = 0; flush_pipe = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
